// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter sharing one FIFO write port between N_REQ producers.
// A winner is chosen in IDLE by scanning req_valid from rr_ptr upward
// (modulo N_REQ). It then owns the write port for one burst. The burst ends
// on an accepted last beat, on the MAX_BURST-th accepted beat, or when the
// granted producer drops valid. Priority then rotates to the next index.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-low reset
//   req_valid  per-requester data valid
//   req_data   per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_last   per-requester final-beat marker
//   req_ready  per-requester accept (beat moves on valid && ready)
//   fifo_full  FIFO full flag
//   fifo_wr    FIFO write strobe
//   fifo_din   FIFO write data (zero when not writing)
//   grant_id   current or most recent granted requester
//   busy       high while a burst is in progress
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*WIDTH-1:0]     req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    input  logic                       fifo_full,
    output logic                       fifo_wr,
    output logic [WIDTH-1:0]           fifo_din,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]   grant_id_reg, grant_id_next;
    logic [CNT_W-1:0]  beat_cnt_reg, beat_cnt_next;

    logic              sel_found;
    logic [ID_W-1:0]   sel_id;
    logic [ID_W:0]     scan_idx;
    logic [ID_W-1:0]   rr_wrap;
    logic              grant_valid;
    logic              grant_last;
    logic              accept;
    logic [WIDTH-1:0]  data_arr [N_REQ];
    logic [N_REQ-1:0]  ready_vec;

    // Unpack the flat data bus and build the one-hot ready vector.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            localparam logic [ID_W-1:0] GI_ID = ID_W'(gi);
            assign data_arr[gi]  = req_data[gi*WIDTH +: WIDTH];
            assign ready_vec[gi] = (state_reg == BURST) && (grant_id_reg == GI_ID) && !fifo_full;
        end
    endgenerate

    assign req_ready = ready_vec;
    assign grant_id  = grant_id_reg;
    assign busy      = (state_reg == BURST);

    // Next round-robin start point after the current grant.
    assign rr_wrap = (grant_id_reg == ID_W'(N_REQ - 1)) ? '0 : grant_id_reg + ID_W'(1);

    // Rotating-priority select. Scanned from highest offset down so the
    // smallest offset from rr_ptr is the last one written and wins.
    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        scan_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(N_REQ);
            end
            if (req_valid[scan_idx[ID_W-1:0]]) begin
                sel_found = 1'b1;
                sel_id    = scan_idx[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            rr_ptr_reg   <= '0;
            grant_id_reg <= '0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rr_ptr_reg   <= rr_ptr_next;
            grant_id_reg <= grant_id_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rr_ptr_next   = rr_ptr_reg;
        grant_id_next = grant_id_reg;
        beat_cnt_next = beat_cnt_reg;
        fifo_wr       = 1'b0;
        fifo_din      = '0;
        grant_valid   = req_valid[grant_id_reg];
        grant_last    = req_last[grant_id_reg];
        accept        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    grant_id_next = sel_id;
                    beat_cnt_next = '0;
                    state_next    = BURST;
                end
            end
            BURST: begin
                // A full FIFO only stalls; only an idle producer, a last
                // beat or the burst limit releases the grant.
                accept  = grant_valid && !fifo_full;
                fifo_wr = accept;
                if (accept) begin
                    fifo_din      = data_arr[grant_id_reg];
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                end
                if (!grant_valid || (accept && (grant_last || beat_cnt_reg == LAST_BEAT))) begin
                    state_next  = IDLE;
                    rr_ptr_next = rr_wrap;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 units later, well clear of both clock edges.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [1:0]  grant_id;
    logic        busy;

    int vectors;
    int miscompares;

    fifo_wr_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [1:0] g, input logic [7:0] d);
        chk({tag, " grant_id"}, grant_id, g);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " req_ready"}, req_ready, 4'b0001 << g);
        chk({tag, " fifo_wr"}, fifo_wr, 1'b1);
        chk({tag, " fifo_din"}, fifo_din, d);
        $display("beat %s: grant=%0d din=%02h", tag, grant_id, fifo_din);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " fifo_wr"}, fifo_wr, 1'b0);
        chk({tag, " req_ready"}, req_ready, 4'b0000);
        chk({tag, " fifo_din"}, fifo_din, 8'h00);
        $display("idle %s: grant=%0d", tag, grant_id);
    endtask

    task automatic chk_stall(input string tag, input logic [1:0] g);
        chk({tag, " grant_id"}, grant_id, g);
        chk({tag, " busy"}, busy, 1'b1);
        chk({tag, " fifo_wr"}, fifo_wr, 1'b0);
        chk({tag, " req_ready"}, req_ready, 4'b0000);
        chk({tag, " fifo_din"}, fifo_din, 8'h00);
        $display("stall %s: grant=%0d", tag, grant_id);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        req_valid   = 4'b0000;
        req_data    = 32'h0;
        req_last    = 4'b0000;
        fifo_full   = 1'b0;

        // Reset state
        #2;
        chk_idle("reset");
        chk("reset grant_id", grant_id, 2'd0);
        next_cycle();
        next_cycle();
        reset = 1'b1;

        // Single requester 1, three beats, last on the third
        req_valid = 4'b0010;
        req_data[15:8] = 8'h11;
        #2 chk_idle("t1 request");
        next_cycle();
        #2 chk_beat("t1 b1", 2'd1, 8'h11);
        next_cycle();
        req_data[15:8] = 8'h22;
        #2 chk_beat("t1 b2", 2'd1, 8'h22);
        next_cycle();
        req_data[15:8] = 8'h33;
        req_last = 4'b0010;
        #2 chk_beat("t1 b3", 2'd1, 8'h33);
        next_cycle();

        // Everyone requests; rr_ptr=2 so grants run 2,3,0,1,2
        req_last  = 4'b0000;
        req_valid = 4'b1111;
        req_data  = 32'hA3A2A1A0;
        #2 chk_idle("t2 start");
        chk("t2 start grant_id hold", grant_id, 2'd1);
        for (int b = 0; b < 5; b++) begin
            next_cycle();
            for (int k = 0; k < 4; k++) begin
                #2 chk_beat($sformatf("t2 burst%0d beat%0d", b, k), 2'((2 + b) % 4), 8'(8'hA0 + (2 + b) % 4));
                next_cycle();
            end
            if (b == 4) req_valid = 4'b0000;
            #2 chk_idle($sformatf("t2 gap%0d", b));
        end
        next_cycle();

        // Requester 2 with a 3-cycle full stall after beat 2; others
        // assert valid once the grant is held and must stay unready.
        req_valid = 4'b0100;
        req_data  = 32'hE351E1E0;
        #2 chk_idle("t3 request");
        next_cycle();
        req_valid = 4'b1111;
        #2 chk_beat("t3 b1", 2'd2, 8'h51);
        next_cycle();
        req_data[23:16] = 8'h52;
        #2 chk_beat("t3 b2", 2'd2, 8'h52);
        next_cycle();
        req_data[23:16] = 8'h53;
        fifo_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #2 chk_stall($sformatf("t3 full%0d", s), 2'd2);
            next_cycle();
        end
        fifo_full = 1'b0;
        #2 chk_beat("t3 b3", 2'd2, 8'h53);
        next_cycle();
        req_data[23:16] = 8'h54;
        #2 chk_beat("t3 b4", 2'd2, 8'h54);
        next_cycle();
        req_valid = 4'b0000;
        #2 chk_idle("t3 end");
        chk("t3 end grant_id hold", grant_id, 2'd2);
        next_cycle();

        // Reset mid-burst: rr_ptr=3, only requester 1 valid -> grant 1
        req_valid = 4'b0010;
        req_data  = 32'h00006100;
        #2 chk_idle("t5 request");
        next_cycle();
        #2 chk_beat("t5 b1", 2'd1, 8'h61);
        next_cycle();
        req_data[15:8] = 8'h62;
        #2 chk_beat("t5 b2 pre", 2'd1, 8'h62);
        reset = 1'b0;
        #1;
        chk_idle("t5 in reset");
        chk("t5 in reset grant_id", grant_id, 2'd0);
        next_cycle();
        reset     = 1'b1;
        req_valid = 4'b1111;
        req_data  = 32'h73727170;
        #2 chk_idle("t5 released");
        next_cycle();

        // Requester 0 granted first after reset, then drops valid after
        // one beat with requester 3 pending.
        req_valid = 4'b1001;
        #2 chk_beat("t4 b1", 2'd0, 8'h70);
        next_cycle();
        req_valid = 4'b1000;
        #2;
        chk("t4 drop busy", busy, 1'b1);
        chk("t4 drop fifo_wr", fifo_wr, 1'b0);
        chk("t4 drop req_ready", req_ready, 4'b0001);
        $display("drop t4: grant=%0d", grant_id);
        next_cycle();
        #2 chk_idle("t4 gap");
        chk("t4 gap grant_id hold", grant_id, 2'd0);
        next_cycle();
        req_last = 4'b1000;
        #2 chk_beat("t4 r3", 2'd3, 8'h73);
        next_cycle();
        req_valid = 4'b0000;
        req_last  = 4'b0000;
        #2 chk_idle("t4 end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
